// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler
//   Transmit queue between the CPU's UART data register and the UART emitter.
//   CPU writes land in a DEPTH-entry circular FIFO. A small FSM pops the head
//   byte, presents it on a valid/ready handshake, and leaves a one-cycle gap
//   after each transfer so the emitter can deassert ready.
//   status = {21'b0, ovf, full, nempty, count[7:0]}
//
//   Optional build macro: UART_TXQ_OVF_STICKY_EN
//     defined   - status bit 10 is a sticky overflow flag. It is set by any
//                 dropped write and cleared by status_rd. Set wins over clear.
//     undefined - status bit 10 reads 0, status_rd is ignored, and no
//                 overflow flop exists.
module uart_tx_scheduler #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        wr_valid,
    input  logic [7:0]  wr_data,
    input  logic        status_rd,
    output logic [31:0] status,
    output logic [7:0]  uart_data,
    output logic        uart_valid,
    input  logic        uart_ready,
    output logic        idle
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_GAP
    } state_t;

    localparam logic [ADDR_W:0] FULL_COUNT = DEPTH[ADDR_W:0];

    state_t            state;
    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   count;
    logic [7:0]        count8;
    logic              full;
    logic              nempty;
    logic              push;
    logic              pop;
    logic              ovf;

    // full and nempty come only from the registered count. A pop in the
    // same cycle therefore never makes room for a write.
    assign full   = (count == FULL_COUNT);
    assign nempty = (count != '0);
    assign push   = wr_valid & ~full;
    assign pop    = (state == S_IDLE) & nempty;

    // Zero-extend the occupancy into the 8-bit status field.
    always_comb begin
        count8             = '0;
        count8[ADDR_W:0]   = count;
    end

    // FIFO storage. The data RAM needs no reset: nothing reads an entry
    // before it has been written.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointer and occupancy bookkeeping. The pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Emitter handshake FSM with registered valid/data outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= S_IDLE;
            uart_valid <= 1'b0;
            uart_data  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (nempty) begin
                        uart_data  <= mem[rd_ptr];
                        uart_valid <= 1'b1;
                        state      <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (uart_ready) begin
                        uart_valid <= 1'b0;
                        state      <= S_GAP;
                    end
                end
                S_GAP: begin
                    state <= S_IDLE;
                end
                default: begin
                    uart_valid <= 1'b0;
                    state      <= S_IDLE;
                end
            endcase
        end
    end

`ifdef UART_TXQ_OVF_STICKY_EN
    // Sticky overflow flag. A drop in the same cycle as status_rd keeps it set.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ovf <= 1'b0;
        end else if (wr_valid & full) begin
            ovf <= 1'b1;
        end else if (status_rd) begin
            ovf <= 1'b0;
        end
    end
`else
    logic unused_status_rd;

    assign ovf              = 1'b0;
    assign unused_status_rd = status_rd;
`endif

    assign status = {21'b0, ovf, full, nempty, count8};
    assign idle   = ~nempty & (state == S_IDLE);

endmodule
